// File: rtl/rv_pkg.sv
// Shared RISC-V datapath types.
// RegfileWriteSelector picks the writeback result source. LoadFunct3 encodes the
// load size and signedness, using the funct3 field values.
package rv_pkg;

  typedef enum logic [2:0] {
    DMEM   = 3'd0,
    IMM    = 3'd1,
    ALU    = 3'd2,
    PC_INC = 3'd3,
    U_LT   = 3'd4,
    S_LT   = 3'd5
  } RegfileWriteSelector;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } LoadFunct3;

endpackage

// File: rtl/regfile_writeback_stage_if.sv
// Execute -> writeback instruction bundle with a valid/ready handshake.
//   master: execute side, which drives the instruction fields and inValid.
//   slave : writeback stage, which drives inReady.
//   inValid/inReady, inSel, inRd, inAluOut, inImm, inPcInc, inSLT, inULT,
//   inLoadFunct3, inByteOffset
interface regfile_writeback_stage_if
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  localparam int OFF_W  = $clog2(XLEN / 8)
);
  logic                inValid;
  logic                inReady;
  RegfileWriteSelector inSel;
  logic [RADDR_W-1:0]  inRd;
  logic [XLEN-1:0]     inAluOut;
  logic [XLEN-1:0]     inImm;
  logic [XLEN-1:0]     inPcInc;
  logic                inSLT;
  logic                inULT;
  LoadFunct3           inLoadFunct3;
  logic [OFF_W-1:0]    inByteOffset;

  modport master (
    output inValid, inSel, inRd, inAluOut, inImm, inPcInc, inSLT, inULT,
           inLoadFunct3, inByteOffset,
    input  inReady
  );

  modport slave (
    input  inValid, inSel, inRd, inAluOut, inImm, inPcInc, inSLT, inULT,
           inLoadFunct3, inByteOffset,
    output inReady
  );
endinterface

// File: rtl/regfile_writeback_stage_load_align_extend.sv
// Combinational load data alignment and extension.
//   data   : raw aligned memory word
//   offset : byte address low bits; bits below the access size are ignored
//   funct3 : load size and signedness
//   result : lane shifted down and sign- or zero-extended to XLEN
// On XLEN=32, LD, LWU and undefined funct3 codes behave as LW (the whole word).
module load_align_extend
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] offset,
  input  LoadFunct3        funct3,
  output logic [XLEN-1:0]  result
);

  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      word_lane;
  logic [OFF_W-2:0] half_idx;
  logic             word_idx;
  logic [XLEN-1:0]  lw_result;

  always_comb begin
    half_idx  = offset[OFF_W-1:1];
    // Only a 64-bit word holds two 32-bit lanes; on XLEN=32 the word lane is fixed at 0.
    word_idx  = (XLEN == 64) ? offset[OFF_W-1] : 1'b0;
    byte_lane = data[{offset, 3'b000} +: 8];
    half_lane = data[{half_idx, 4'b0000} +: 16];
    word_lane = data[{word_idx, 5'b00000} +: 32];
    lw_result = XLEN'($signed(word_lane));
  end

  always_comb begin
    result = lw_result;
    case (funct3)
      LB:      result = XLEN'($signed(byte_lane));
      LBU:     result = XLEN'(byte_lane);
      LH:      result = XLEN'($signed(half_lane));
      LHU:     result = XLEN'(half_lane);
      LWU:     result = (XLEN == 64) ? XLEN'(word_lane) : lw_result;
      LD:      result = (XLEN == 64) ? data : lw_result;
      default: result = lw_result;
    endcase
  end

endmodule

// File: rtl/regfile_writeback_stage.sv
// Registered writeback stage between execute and the register file.
//   clk, rstN       : clock, synchronous active-low reset
//   ex              : execute instruction bundle (slave side)
//   dmemRspValid/Data : variable-latency load response
//   rfWrEn/Addr/Data  : registered regfile write port (one-cycle write pulse)
//   busy            : a load is outstanding
// Non-load results are written one cycle after acceptance. A load parks in
// WAIT_MEM until the response arrives and is written one cycle after that.
// A write to x0 follows normal timing but keeps rfWrEn low.
module regfile_writeback_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  localparam int OFF_W  = $clog2(XLEN / 8)
) (
  input  logic                       clk,
  input  logic                       rstN,
  regfile_writeback_stage_if.slave   ex,
  input  logic                       dmemRspValid,
  input  logic [XLEN-1:0]            dmemRspData,
  output logic                       rfWrEn,
  output logic [RADDR_W-1:0]         rfWrAddr,
  output logic [XLEN-1:0]            rfWrData,
  output logic                       busy
);

  typedef enum logic {IDLE, WAIT_MEM} wb_state_e;

  wb_state_e          state, state_next;
  logic               accept;
  logic [XLEN-1:0]    mux_out;
  logic [XLEN-1:0]    load_data;
  logic [RADDR_W-1:0] ld_rd;
  LoadFunct3          ld_f3;
  logic [OFF_W-1:0]   ld_off;
  logic               wr_fire;
  logic [RADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]    wr_data;

  assign accept = ex.inValid && ex.inReady;

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && ex.inSel == DMEM) state_next = WAIT_MEM;
      WAIT_MEM: if (dmemRspValid)               state_next = IDLE;
      default:                                  state_next = IDLE;
    endcase
  end

  always_comb begin
    mux_out = ex.inAluOut;
    case (ex.inSel)
      IMM:     mux_out = ex.inImm;
      PC_INC:  mux_out = ex.inPcInc;
      U_LT:    mux_out = XLEN'(ex.inULT);
      S_LT:    mux_out = XLEN'(ex.inSLT);
      default: mux_out = ex.inAluOut;
    endcase
  end

  always_comb begin
    ex.inReady = (state == IDLE);
    busy       = (state == WAIT_MEM);
    wr_fire    = 1'b0;
    wr_addr    = ex.inRd;
    wr_data    = mux_out;
    case (state)
      IDLE: wr_fire = accept && (ex.inSel != DMEM);
      WAIT_MEM: begin
        wr_fire = dmemRspValid;
        wr_addr = ld_rd;
        wr_data = load_data;
      end
      default: wr_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      ld_rd  <= '0;
      ld_f3  <= LB;
      ld_off <= '0;
    end else if (accept && ex.inSel == DMEM) begin
      ld_rd  <= ex.inRd;
      ld_f3  <= ex.inLoadFunct3;
      ld_off <= ex.inByteOffset;
    end
  end

  load_align_extend #(.XLEN(XLEN)) u_align (
    .data   (dmemRspData),
    .offset (ld_off),
    .funct3 (ld_f3),
    .result (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rfWrEn   <= 1'b0;
      rfWrAddr <= '0;
      rfWrData <= '0;
    end else begin
      rfWrEn <= wr_fire && (wr_addr != '0);
      if (wr_fire) begin
        rfWrAddr <= wr_addr;
        rfWrData <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_stage.sv
module tb_regfile_writeback_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        rsp32, rsp64;
  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic        we32, we64, busy32, busy64;
  logic [4:0]  wa32, wa64;
  logic [31:0] wd32;
  logic [63:0] wd64;

  regfile_writeback_stage_if #(.XLEN(32), .RADDR_W(5)) ex32 ();
  regfile_writeback_stage_if #(.XLEN(64), .RADDR_W(5)) ex64 ();

  regfile_writeback_stage #(.XLEN(32), .RADDR_W(5)) dut32 (
    .clk(clk), .rstN(rstN), .ex(ex32),
    .dmemRspValid(rsp32), .dmemRspData(rdata32),
    .rfWrEn(we32), .rfWrAddr(wa32), .rfWrData(wd32), .busy(busy32)
  );

  regfile_writeback_stage #(.XLEN(64), .RADDR_W(5)) dut64 (
    .clk(clk), .rstN(rstN), .ex(ex64),
    .dmemRspValid(rsp64), .dmemRspData(rdata64),
    .rfWrEn(we64), .rfWrAddr(wa64), .rfWrData(wd64), .busy(busy64)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write pulse must match the oldest expected write, cycle included.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (we32 !== 1'b0) begin
      if (q32.size() == 0) chk("wr32_unexpected", 64'(we32), 64'd0);
      else begin
        e = q32.pop_front();
        chk("wr32_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr32_addr", 64'(wa32), 64'(e.rd));
        chk("wr32_data", 64'(wd32), e.data);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (we64 !== 1'b0) begin
      if (q64.size() == 0) chk("wr64_unexpected", 64'(we64), 64'd0);
      else begin
        e = q64.pop_front();
        chk("wr64_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr64_addr", 64'(wa64), 64'(e.rd));
        chk("wr64_data", wd64, e.data);
      end
    end
  end

  // Presents one instruction for one cycle; called at a negedge, returns at the next.
  task automatic issue(input bit w, input RegfileWriteSelector sel, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] imm, input logic [63:0] pc,
                       input logic slt, input logic ult, input LoadFunct3 f3,
                       input logic [2:0] off, input bit expw, input logic [63:0] expd);
    if (!w) begin
      chk("ready32_before_issue", 64'(ex32.inReady), 64'd1);
      ex32.inValid = 1'b1; ex32.inSel = sel; ex32.inRd = rd;
      ex32.inAluOut = alu[31:0]; ex32.inImm = imm[31:0]; ex32.inPcInc = pc[31:0];
      ex32.inSLT = slt; ex32.inULT = ult; ex32.inLoadFunct3 = f3;
      ex32.inByteOffset = off[1:0];
      if (expw) q32.push_back(exp_t'{cyc + 1, rd, expd});
    end else begin
      chk("ready64_before_issue", 64'(ex64.inReady), 64'd1);
      ex64.inValid = 1'b1; ex64.inSel = sel; ex64.inRd = rd;
      ex64.inAluOut = alu; ex64.inImm = imm; ex64.inPcInc = pc;
      ex64.inSLT = slt; ex64.inULT = ult; ex64.inLoadFunct3 = f3;
      ex64.inByteOffset = off;
      if (expw) q64.push_back(exp_t'{cyc + 1, rd, expd});
    end
    @(negedge clk);
    ex32.inValid = 1'b0;
    ex64.inValid = 1'b0;
  endtask

  task automatic op(input bit w, input RegfileWriteSelector sel, input logic [4:0] rd,
                    input logic [63:0] alu, input logic [63:0] imm, input logic [63:0] pc,
                    input logic slt, input logic ult, input logic [63:0] expd);
    issue(w, sel, rd, alu, imm, pc, slt, ult, LW, 3'd0, rd != 5'd0, expd);
  endtask

  task automatic ld(input bit w, input LoadFunct3 f3, input logic [4:0] rd, input logic [2:0] off);
    issue(w, DMEM, rd, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, f3, off, 1'b0, 64'h0);
  endtask

  task automatic resp(input bit w, input logic [63:0] d, input logic [4:0] rd,
                      input bit expw, input logic [63:0] expd);
    if (!w) begin
      rsp32 = 1'b1; rdata32 = d[31:0];
      if (expw) q32.push_back(exp_t'{cyc + 1, rd, expd});
    end else begin
      rsp64 = 1'b1; rdata64 = d;
      if (expw) q64.push_back(exp_t'{cyc + 1, rd, expd});
    end
    @(negedge clk);
    rsp32 = 1'b0;
    rsp64 = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; rsp32 = 1'b0; rsp64 = 1'b0; rdata32 = '0; rdata64 = '0;
    ex32.inValid = 1'b0; ex32.inSel = ALU; ex32.inRd = '0; ex32.inAluOut = '0;
    ex32.inImm = '0; ex32.inPcInc = '0; ex32.inSLT = 1'b0; ex32.inULT = 1'b0;
    ex32.inLoadFunct3 = LB; ex32.inByteOffset = '0;
    ex64.inValid = 1'b0; ex64.inSel = ALU; ex64.inRd = '0; ex64.inAluOut = '0;
    ex64.inImm = '0; ex64.inPcInc = '0; ex64.inSLT = 1'b0; ex64.inULT = 1'b0;
    ex64.inLoadFunct3 = LB; ex64.inByteOffset = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_we", 64'(we32), 64'd0);
    chk("rst_addr", 64'(wa32), 64'd0);
    chk("rst_data", 64'(wd32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ex32.inReady), 64'd1);

    // Back-to-back ALU writes and the other mux sources
    op(0, ALU, 5'd3, 64'h1234, 64'h0, 64'h0, 0, 0, 64'h1234);
    op(0, ALU, 5'd4, 64'h55, 64'h0, 64'h0, 0, 0, 64'h55);
    op(0, IMM, 5'd5, 64'h1, 64'hCAFE, 64'h0, 0, 0, 64'hCAFE);
    op(0, PC_INC, 5'd6, 64'h1, 64'h2, 64'h104, 0, 0, 64'h104);
    op(0, S_LT, 5'd7, 64'hFFFF_FFFF, 64'h0, 64'h0, 1, 0, 64'h1);
    op(0, U_LT, 5'd8, 64'hFFFF_FFFF, 64'h0, 64'h0, 1, 0, 64'h0);
    op(0, U_LT, 5'd9, 64'h0, 64'h0, 64'h0, 0, 1, 64'h1);
    op(0, RegfileWriteSelector'(3'd6), 5'd10, 64'hA5A5, 64'h1, 64'h2, 1, 1, 64'hA5A5);
    @(negedge clk);

    // LB with a slow response: stall visible for every waiting cycle
    ld(0, LB, 5'd11, 3'd3);
    for (int i = 0; i < 4; i++) begin
      chk("lb_wait_ready", 64'(ex32.inReady), 64'd0);
      chk("lb_wait_busy", 64'(busy32), 64'd1);
      @(negedge clk);
    end
    chk("lb_rsp_ready", 64'(ex32.inReady), 64'd0);
    resp(0, 64'h8000_0000, 5'd11, 1, 64'hFFFF_FF80);
    chk("lb_done_busy", 64'(busy32), 64'd0);

    // Halfword / word loads on XLEN=32, including misaligned and undefined funct3
    ld(0, LHU, 5'd12, 3'd2);
    resp(0, 64'hBEEF_0000, 5'd12, 1, 64'h0000_BEEF);
    ld(0, LH, 5'd13, 3'd3);
    resp(0, 64'h8001_0000, 5'd13, 1, 64'hFFFF_8001);
    ld(0, LW, 5'd14, 3'd1);
    resp(0, 64'h8765_4321, 5'd14, 1, 64'h8765_4321);
    ld(0, LoadFunct3'(3'd7), 5'd15, 3'd2);
    resp(0, 64'h1357_9BDF, 5'd15, 1, 64'h1357_9BDF);
    ld(0, LBU, 5'd16, 3'd1);
    resp(0, 64'h0000_F000, 5'd16, 1, 64'h0000_00F0);

    // XLEN=64 loads and a zero-extended compare flag
    ld(1, LWU, 5'd1, 3'd4);
    resp(1, 64'h8000_0001_0000_0000, 5'd1, 1, 64'h0000_0000_8000_0001);
    ld(1, LW, 5'd2, 3'd5);
    resp(1, 64'h8000_0001_0000_0000, 5'd2, 1, 64'hFFFF_FFFF_8000_0001);
    ld(1, LD, 5'd3, 3'd3);
    resp(1, 64'h0123_4567_89AB_CDEF, 5'd3, 1, 64'h0123_4567_89AB_CDEF);
    ld(1, LB, 5'd4, 3'd7);
    resp(1, 64'h7F00_0000_0000_0000, 5'd4, 1, 64'h7F);
    op(1, S_LT, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 0, 64'h1);

    // Response while idle must not write
    resp(0, 64'hDEAD_BEEF, 5'd0, 0, 64'h0);
    chk("idle_rsp_busy", 64'(busy32), 64'd0);
    chk("idle_rsp_we", 64'(we32), 64'd0);

    // Reset mid-WAIT_MEM, then a stale response
    ld(0, LW, 5'd17, 3'd0);
    chk("pre_rst_busy", 64'(busy32), 64'd1);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_we", 64'(we32), 64'd0);
    chk("midrst_data", 64'(wd32), 64'd0);
    chk("midrst_busy", 64'(busy32), 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(ex32.inReady), 64'd1);
    resp(0, 64'h1111_2222, 5'd0, 0, 64'h0);
    chk("stale_rsp_we", 64'(we32), 64'd0);

    // rd=0 completes without a write strobe
    op(0, ALU, 5'd0, 64'h77, 64'h0, 64'h0, 0, 0, 64'h77);
    chk("rd0_we", 64'(we32), 64'd0);
    chk("rd0_ready", 64'(ex32.inReady), 64'd1);

    for (int i = 0; i < 10 && (q32.size() + q64.size()) != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(q32.size() + q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
